// File: rtl/serial_cla_subtractor.sv
// Multi-cycle subtractor: diff = a - b, one 4-bit lookahead slice per clock, LSB slice first.
// Valid/ready on both sides; the result holds in DONE until the consumer takes it.
module serial_cla_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CntW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            r_state, w_state_next;
  logic [WIDTH-1:0]  r_a, r_b, r_diff;
  logic [CntW-1:0]   r_cnt;
  logic              r_carry;
  logic              r_out_valid, r_borrow, r_overflow, r_zero;

  logic              w_in_xfer, w_out_xfer, w_last;
  logic [CntW+1:0]   w_sh;
  logic [3:0]        w_a_sl, w_nb_sl, w_p, w_g, w_sum;
  logic              w_c0, w_c1, w_c2, w_c3, w_gp, w_gg;
  logic [WIDTH-1:0]  w_diff_next;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = r_out_valid & out_ready;
  assign w_last     = (r_cnt == CntW'(NSLICE - 1));

  // Slice selection from the latched operands; subtrahend inverted for a + ~b + 1.
  assign w_sh    = {r_cnt, 2'b00};
  assign w_a_sl  = 4'(r_a >> w_sh);
  assign w_nb_sl = ~4'(r_b >> w_sh);
  assign w_p     = w_a_sl ^ w_nb_sl;
  assign w_g     = w_a_sl & w_nb_sl;

  // Two-level lookahead: bit carries for the sum, group propagate/generate for carry-out.
  assign w_c0 = w_g[0] | (w_p[0] & r_carry);
  assign w_c1 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
  assign w_c2 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
              | (w_p[2] & w_p[1] & w_p[0] & r_carry);
  assign w_gp = &w_p;
  assign w_gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign w_c3 = w_gg | (w_gp & r_carry);

  assign w_sum = w_p ^ {w_c2, w_c1, w_c0, r_carry};

  always_comb begin
    w_diff_next = (r_diff & ~(WIDTH'(4'hF) << w_sh)) | (WIDTH'(w_sum) << w_sh);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (in_valid) w_state_next = StRun;
      StRun:  if (w_last) w_state_next = StDone;
      StDone: begin
        if (out_ready) w_state_next = in_valid ? StRun : StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Output logic; DONE accepts on the same edge the result is consumed.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      in_ready = (r_state == StIdle) | ((r_state == StDone) & out_ready);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_diff      <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_out_valid <= 1'b0;
      r_borrow    <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      if (w_out_xfer) r_out_valid <= 1'b0;
      if (w_in_xfer) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= 1'b1;
        r_cnt   <= '0;
      end else if (r_state == StRun) begin
        r_diff  <= w_diff_next;
        r_carry <= w_c3;
        r_cnt   <= r_cnt + CntW'(1);
        if (w_last) begin
          r_out_valid <= 1'b1;
          r_borrow    <= ~w_c3;
          r_overflow  <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &
                         (w_diff_next[WIDTH-1] != r_a[WIDTH-1]);
          r_zero      <= (w_diff_next == '0);
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign borrow    = r_borrow;
  assign overflow  = r_overflow;
  assign zero      = r_zero;

endmodule

// File: tb/tb_serial_cla_subtractor.sv
// Scoreboard bench for serial_cla_subtractor at WIDTH=16: directed cases, backpressure,
// mid-run reset and a random sweep with stalls.
module tb_serial_cla_subtractor;

  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             br;
    logic             ov;
    logic             z;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;
  logic             zero;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  serial_cla_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    exp_t e;
    e.d  = x - y;
    e.br = (x < y);
    e.ov = (x[WIDTH-1] != y[WIDTH-1]) && (e.d[WIDTH-1] != x[WIDTH-1]);
    e.z  = (e.d == '0);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, transfers one operand pair and records its expected result.
  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input exp_t e);
    int t = 0;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_wait in_ready stayed %b, required 1", in_ready);
    end
    in_valid = 1'b1;
    a        = x;
    b        = y;
    step();
    in_valid = 1'b0;
    sb.push_back(e);
  endtask

  // Counts edges to out_valid, compares with the scoreboard, stalls, then optionally consumes.
  task automatic check_result(input int stall, input bit consume);
    int   lat = 0;
    exp_t e;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    n_checks++;
    if (lat !== NSLICE) begin
      n_errors++;
      $display("FAIL latency got %0d edges, required %0d", lat, NSLICE);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard empty with out_valid=%b", out_valid);
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (diff !== e.d) begin
      n_errors++;
      $display("FAIL diff got %h, required %h", diff, e.d);
    end
    n_checks++;
    if (borrow !== e.br) begin
      n_errors++;
      $display("FAIL borrow got %b, required %b (diff %h)", borrow, e.br, e.d);
    end
    n_checks++;
    if (overflow !== e.ov) begin
      n_errors++;
      $display("FAIL overflow got %b, required %b (diff %h)", overflow, e.ov, e.d);
    end
    n_checks++;
    if (zero !== e.z) begin
      n_errors++;
      $display("FAIL zero got %b, required %b (diff %h)", zero, e.z, e.d);
    end
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a         = WIDTH'($urandom);
      b         = WIDTH'($urandom);
      step();
      n_checks++;
      if (out_valid !== 1'b1 || diff !== e.d || borrow !== e.br || overflow !== e.ov ||
          zero !== e.z) begin
        n_errors++;
        $display("FAIL stall_hold got v=%b d=%h br=%b ov=%b z=%b, required v=1 d=%h br=%b ov=%b z=%b",
                 out_valid, diff, borrow, overflow, zero, e.d, e.br, e.ov, e.z);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_in_ready got %b, required 0", in_ready);
      end
    end
    in_valid = 1'b0;
    if (consume) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL consume out_valid got %b, required 0", out_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #12;
    n_checks++;
    if (out_valid !== 1'b0 || diff !== '0 || borrow !== 1'b0 || overflow !== 1'b0 ||
        zero !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs got v=%b d=%h br=%b ov=%b z=%b, required all 0",
               out_valid, diff, borrow, overflow, zero);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_in_ready got %b, required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    exp_t e;
    e = '{d: 16'h1200, br: 1'b0, ov: 1'b0, z: 1'b0};
    send(16'h1234, 16'h0034, e);
    check_result(0, 1'b1);
    e = '{d: 16'hFFFF, br: 1'b1, ov: 1'b0, z: 1'b0};
    send(16'h0000, 16'h0001, e);
    check_result(0, 1'b1);
    e = '{d: 16'h7FFF, br: 1'b0, ov: 1'b1, z: 1'b0};
    send(16'h8000, 16'h0001, e);
    check_result(1, 1'b1);
    e = '{d: 16'h0000, br: 1'b0, ov: 1'b0, z: 1'b1};
    send(16'hABCD, 16'hABCD, e);
    check_result(0, 1'b1);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    e = '{d: 16'h1110, br: 1'b0, ov: 1'b0, z: 1'b0};
    send(16'h1111, 16'h0001, e);
    check_result(10, 1'b0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = 16'h0005;
    b         = 16'h0003;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_in_ready got %b, required 1", in_ready);
    end
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    sb.push_back('{d: 16'h0002, br: 1'b0, ov: 1'b0, z: 1'b0});
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_consume out_valid got %b, required 0", out_valid);
    end
    check_result(0, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    e = model(16'h1234, 16'h1111);
    send(16'h1234, 16'h1111, e);
    void'(sb.pop_back());
    step();
    step();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || diff !== '0 || borrow !== 1'b0 || overflow !== 1'b0 ||
        zero !== 1'b0) begin
      n_errors++;
      $display("FAIL midrun_reset got v=%b d=%h br=%b ov=%b z=%b, required all 0",
               out_valid, diff, borrow, overflow, zero);
    end
    step();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL midrun_release got in_ready=%b out_valid=%b, required 1 and 0",
               in_ready, out_valid);
    end
    e = '{d: 16'h000F, br: 1'b0, ov: 1'b0, z: 1'b0};
    send(16'h0010, 16'h0001, e);
    check_result(0, 1'b1);
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] x, y;
    for (int i = 0; i < 1000; i++) begin
      x = WIDTH'($urandom);
      y = WIDTH'($urandom);
      if (i % 50 == 0) y = x;
      if (i % 50 == 1) begin
        x = 16'h8000;
        y = WIDTH'($urandom_range(1, 16'h7FFF));
      end
      send(x, y, model(x, y));
      check_result(int'($urandom_range(0, 3)), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_leftover got %0d entries, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
